sram_ctrl: RTL
==============

SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 16: width of the host data words and the SRAM data bus.
REQ-002 Parameter ADDR_WIDTH, default 16: width of the host address and the SRAM address.
REQ-003 Parameter READ_WAIT, default 2: number of access cycles with notCS/notOE low; must be >= 1.
REQ-004 Parameter WRITE_WAIT, default 2: number of cycles notWE is held low; must be >= 1.
REQ-005 Port clock, in, 1: single clock; every state change happens on its rising edge.
REQ-006 Port reset, in, 1: synchronous, active-high reset.
REQ-007 Port req, in, 1: host transaction request, level-sensitive.
REQ-008 Port we, in, 1: 1 selects a write, 0 selects a read.
REQ-009 Port addr, in, ADDR_WIDTH: host address.
REQ-010 Port wdata, in, DATA_WIDTH: host write data.
REQ-011 Port rdata, out, DATA_WIDTH: registered read data.
REQ-012 Port ack, out, 1: one-cycle transaction-complete pulse.
REQ-013 Port busy, out, 1: high whenever the state is not IDLE.
REQ-014 Port sramAddr, out, ADDR_WIDTH: registered SRAM address.
REQ-015 Port sramData, inout, DATA_WIDTH: SRAM data bus; high-Z unless the controller is driving write data.
REQ-016 Ports sramNotCS, sramNotOE, sramNotWE, out, 1 each: active-low SRAM strobes, all registered.

Function
REQ-017 States: IDLE, RD_ACCESS, RD_DONE, WR_SETUP, WR_PULSE, WR_HOLD.
REQ-018 IDLE -> acceptance: the block accepts a request on a rising edge when state = IDLE and req = 1, and latches addr, we and wdata on that same edge.
REQ-019 req while busy: req is ignored whenever state != IDLE, so the host holds req until ack to be served.
REQ-020 Read path: acceptance -> RD_ACCESS for exactly READ_WAIT cycles with sramNotCS=0, sramNotOE=0, sramNotWE=1 and sramData released.
REQ-021 Read capture: rdata captures sramData on the edge that ends the last RD_ACCESS cycle, then the state goes to RD_DONE.
REQ-022 RD_DONE: ack=1, sramNotOE=1, sramNotCS=1; the next state is IDLE.
REQ-023 Read latency: ack is high in the (READ_WAIT+1)th cycle after the acceptance edge.
REQ-024 Write path: acceptance -> WR_SETUP for 1 cycle with sramNotCS=0, sramNotWE=1, and sramAddr and sramData driven.
REQ-025 WR_PULSE: sramNotWE=0 for exactly WRITE_WAIT cycles, with address and data stable.
REQ-026 WR_HOLD: 1 cycle with sramNotWE=1, data still driven, sramNotCS=0 and ack=1; the next state is IDLE, which releases sramData.
REQ-027 Write latency: ack is high in the (WRITE_WAIT+2)th cycle after the acceptance edge.
REQ-028 sramNotOE and sramNotWE are never both 0 in any cycle.
REQ-029 sramData is never driven while sramNotOE=0.
REQ-030 Turnaround: after an ack the block spends at least one IDLE cycle before the next acceptance, giving a minimum gap of 1 cycle between the end of one transaction and the start of the next.
REQ-031 Wait counter: width is clog2(max(READ_WAIT, WRITE_WAIT)+1); it loads on state entry and decrements to 0 with no wrap.
REQ-032 rdata holds its value until the next read capture; writes do not change it.
REQ-033 In IDLE: sramNotCS=sramNotOE=sramNotWE=1, sramData=Z, ack=0, busy=0.

Reset
REQ-034 reset=1 at a rising edge forces IDLE, with sramNotCS=sramNotOE=sramNotWE=1, sramData=Z, ack=0, busy=0, rdata=0 and sramAddr=0.
REQ-035 Reset mid-transaction aborts the transaction: no ack is issued and all strobes go high on that edge; a write pulse may be cut short.
REQ-036 reset takes priority over req on the same edge.

Verification
(DATA_WIDTH=4, ADDR_WIDTH=4, READ_WAIT=2, WRITE_WAIT=2; the async SRAM model is preloaded from mem.lst with addr0=F and addr1=E.)
REQ-037 Read preload: read addr 0 -> ack 3 cycles after acceptance with rdata=F; then read addr 1 -> rdata=E.
REQ-038 Write/readback: write addr i with data i for i=3..A, then read each -> every rdata=i; each write ack comes 4 cycles after acceptance, and notWE is low for exactly 2 cycles.
REQ-039 Held req: hold req=1 with we=0 continuously -> one acceptance per transaction; acks are separated by at least 1 IDLE cycle, and busy=0 in the gap cycles.
REQ-040 Reset mid-operation: assert reset during the WR_PULSE of a write to addr 5 -> all strobes are 1 on the next edge, no ack appears, and a following read of addr 5 returns a defined value only if the aborted write had not yet started its pulse.
REQ-041 Bus safety: a checker runs over all scenarios -> sramNotOE=0 together with sramNotWE=0 never occurs, and sramData is never driven while sramNotOE=0.

Source files
------------

// File: rtl/sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sram_ctrl
// Purpose  : Single-port asynchronous SRAM controller. It accepts one host
//            read or write at a time and sequences registered CS/OE/WE
//            strobes with configurable access and write-pulse lengths.
// Revision : 1.0 - initial release
// ============================================================================
module sram_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int READ_WAIT  = 2,
  parameter int WRITE_WAIT = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  ack,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] sramAddr,
  inout  wire  [DATA_WIDTH-1:0] sramData,
  output logic                  sramNotCS,
  output logic                  sramNotOE,
  output logic                  sramNotWE
);

  // The wait counter only ever holds (wait - 1), so max(wait)+1 states suffice.
  localparam int MAX_WAIT = (READ_WAIT > WRITE_WAIT) ? READ_WAIT : WRITE_WAIT;
  localparam int CNT_W    = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_WAIT - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WRITE_WAIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RD_ACCESS = 3'd1,
    S_RD_DONE   = 3'd2,
    S_WR_SETUP  = 3'd3,
    S_WR_PULSE  = 3'd4,
    S_WR_HOLD   = 3'd5
  } state_t;

  state_t                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic                    drive_q;
  logic                    cs_n_q;
  logic                    oe_n_q;
  logic                    we_n_q;
  logic                    ack_q;
  logic                    busy_q;
  logic                    cnt_zero;

  assign cnt_zero = (cnt_q == '0);

  // Write data is driven only during the write phases; OE is always high then,
  // so the controller and the SRAM can never fight over the bus.
  assign sramData  = drive_q ? wdata_q : {DATA_WIDTH{1'bz}};

  assign rdata     = rdata_q;
  assign ack       = ack_q;
  assign busy      = busy_q;
  assign sramAddr  = addr_q;
  assign sramNotCS = cs_n_q;
  assign sramNotOE = oe_n_q;
  assign sramNotWE = we_n_q;

  // Transaction sequencer: state, wait counter and every registered output.
  // The host's we bit is captured by the choice of read or write branch.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      drive_q <= 1'b0;
      cs_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req) begin
            addr_q  <= addr;
            wdata_q <= wdata;
            busy_q  <= 1'b1;
            cs_n_q  <= 1'b0;
            if (we) begin
              state_q <= S_WR_SETUP;
              drive_q <= 1'b1;
            end else begin
              state_q <= S_RD_ACCESS;
              oe_n_q  <= 1'b0;
              cnt_q   <= RD_LOAD;
            end
          end
        end

        S_RD_ACCESS: begin
          if (cnt_zero) begin
            rdata_q <= sramData;
            state_q <= S_RD_DONE;
            cs_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            ack_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end

        S_RD_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end

        S_WR_SETUP: begin
          state_q <= S_WR_PULSE;
          we_n_q  <= 1'b0;
          cnt_q   <= WR_LOAD;
        end

        S_WR_PULSE: begin
          if (cnt_zero) begin
            state_q <= S_WR_HOLD;
            we_n_q  <= 1'b1;
            ack_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end

        S_WR_HOLD: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          cs_n_q  <= 1'b1;
          drive_q <= 1'b0;
        end

        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          drive_q <= 1'b0;
          cs_n_q  <= 1'b1;
          oe_n_q  <= 1'b1;
          we_n_q  <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
